command_word_sequencer: RTL and testbench



---
 rtl/command_word_sequencer_pkg.sv | 40 ++++
 rtl/command_word_sequencer_bus_write_detector.sv | 45 ++++
 rtl/command_word_sequencer.sv | 142 ++++++++++++++
 tb/tb_command_word_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/command_word_sequencer_pkg.sv
// command_word_sequencer_pkg: state encodings, ICW/OCW bit positions and strobe indices
// shared by the 8259A-style command word sequencer and its bus write detector.
package command_word_sequencer_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } seq_state_e;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_ADI  = 2;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_ID   = 4;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    localparam int OCW3_SEL  = 3;

    localparam int STB_ICW1    = 0;
    localparam int STB_ICW2    = 1;
    localparam int STB_ICW3    = 2;
    localparam int STB_ICW4    = 3;
    localparam int STB_OCW1    = 4;
    localparam int STB_OCW2    = 5;
    localparam int STB_OCW3    = 6;
    localparam int NUM_STROBES = 7;

    // ICW3 is only expected in cascade mode; ICW4 only when ICW1 asked for it.
    function automatic seq_state_e after_icw2(input logic sngl, input logic ic4);
        return !sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
    endfunction

endpackage

// File: rtl/command_word_sequencer_bus_write_detector.sv
// command_word_sequencer_bus_write_detector: synchronizes CS#/WR#/A0/D and flags a completed
// write on the synchronized WR# rising edge, presenting A0/D from the last WR#-low sample.
module command_word_sequencer_bus_write_detector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic       write_pulse,
    output logic       wr_address,
    output logic [7:0] wr_data
);

    localparam int W      = 11;
    localparam int CS_BIT = 10;
    localparam int WR_BIT = 9;
    localparam int A0_BIT = 8;
    // Strobes idle high so leaving reset can never look like a WR# release.
    localparam logic [W-1:0] IDLE = 11'b110_0000_0000;

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE;
            prev_q <= IDLE;
        end else begin
            sync_q[0] <= {chip_select_n, write_enable_n, address, data_bus_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= cur;
        end
    end

    assign write_pulse = !prev_q[CS_BIT] && !prev_q[WR_BIT] && cur[WR_BIT];
    assign wr_address  = prev_q[A0_BIT];
    assign wr_data     = prev_q[7:0];

endmodule

// File: rtl/command_word_sequencer.sv
// command_word_sequencer: tracks the ICW1..ICW4 init sequence, emits one-cycle ICW/OCW strobes
// and holds ICW configuration. Optional sticky seq_error under `define CMD_SEQ_ERROR_EN.
module command_word_sequencer
    import command_word_sequencer_pkg::*;
#(
    parameter int         SYNC_STAGES       = 2,
    parameter logic [4:0] RESET_VECTOR_BASE = 5'h00
) (
    input  logic       clock,
    input  logic       reset_n,
`ifdef CMD_SEQ_ERROR_EN
    input  logic       seq_error_clear,
    output logic       seq_error,
`endif
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_icw1,
    output logic       write_icw2,
    output logic       write_icw3,
    output logic       write_icw4,
    output logic       write_ocw1,
    output logic       write_ocw2,
    output logic       write_ocw3,
    output logic       init_in_progress,
    output logic       config_ltim,
    output logic       config_adi,
    output logic       config_sngl,
    output logic       config_ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       config_upm,
    output logic       config_aeoi,
    output logic       config_ms,
    output logic       config_buf,
    output logic       config_sfnm
);

    seq_state_e             state, next_state;
    logic                   write_pulse;
    logic                   wr_address;
    logic [7:0]             wr_data;
    logic [NUM_STROBES-1:0] strobe_d, strobe_q;

    command_word_sequencer_bus_write_detector #(
        .SYNC_STAGES(SYNC_STAGES)
    ) bus_write_detector (
        .clock         (clock),
        .reset_n       (reset_n),
        .chip_select_n (chip_select_n),
        .write_enable_n(write_enable_n),
        .address       (address),
        .data_bus_in   (data_bus_in),
        .write_pulse   (write_pulse),
        .wr_address    (wr_address),
        .wr_data       (wr_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= READY;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (strobe_d[STB_ICW1])      next_state = WAIT_ICW2;
        else if (strobe_d[STB_ICW2]) next_state = after_icw2(config_sngl, config_ic4);
        else if (strobe_d[STB_ICW3]) next_state = config_ic4 ? WAIT_ICW4 : READY;
        else if (strobe_d[STB_ICW4]) next_state = READY;
    end

    // ICW1 is recognised in every state so a stray init restarts the sequence.
    always_comb begin
        strobe_d = '0;
        if (write_pulse) begin
            if (!wr_address && wr_data[ICW1_ID])
                strobe_d[STB_ICW1] = 1'b1;
            else if (state == READY)
                strobe_d[wr_address ? STB_OCW1 : wr_data[OCW3_SEL] ? STB_OCW3 : STB_OCW2] = 1'b1;
            else if (wr_address)
                strobe_d[state == WAIT_ICW2 ? STB_ICW2 : state == WAIT_ICW3 ? STB_ICW3 : STB_ICW4] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q          <= '0;
            internal_data_bus <= 8'h00;
            config_ltim       <= 1'b0;
            config_adi        <= 1'b0;
            config_sngl       <= 1'b0;
            config_ic4        <= 1'b0;
            vector_base       <= RESET_VECTOR_BASE;
            cascade_config    <= 8'h00;
            {config_sfnm, config_buf, config_ms, config_aeoi, config_upm} <= 5'b0;
        end else begin
            strobe_q <= strobe_d;
            if (write_pulse) internal_data_bus <= wr_data;
            if (strobe_d[STB_ICW1]) begin
                config_ltim <= wr_data[ICW1_LTIM];
                config_adi  <= wr_data[ICW1_ADI];
                config_sngl <= wr_data[ICW1_SNGL];
                config_ic4  <= wr_data[ICW1_IC4];
                {config_sfnm, config_buf, config_ms, config_aeoi, config_upm} <= 5'b0;
            end
            if (strobe_d[STB_ICW2]) vector_base <= wr_data[7:3];
            if (strobe_d[STB_ICW3]) cascade_config <= wr_data;
            if (strobe_d[STB_ICW4]) begin
                config_upm  <= wr_data[ICW4_UPM];
                config_aeoi <= wr_data[ICW4_AEOI];
                config_ms   <= wr_data[ICW4_MS];
                config_buf  <= wr_data[ICW4_BUF];
                config_sfnm <= wr_data[ICW4_SFNM];
            end
        end
    end

`ifdef CMD_SEQ_ERROR_EN
    logic ignored;

    // An OCW-form write while an ICW is still expected is dropped but remembered.
    assign ignored = write_pulse && state != READY && !wr_address && !wr_data[ICW1_ID];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                    seq_error <= 1'b0;
        else if (ignored)                                seq_error <= 1'b1;
        else if (seq_error_clear || strobe_d[STB_ICW1])  seq_error <= 1'b0;
    end
`endif

    assign init_in_progress = state != READY;
    assign write_icw1 = strobe_q[STB_ICW1];
    assign write_icw2 = strobe_q[STB_ICW2];
    assign write_icw3 = strobe_q[STB_ICW3];
    assign write_icw4 = strobe_q[STB_ICW4];
    assign write_ocw1 = strobe_q[STB_OCW1];
    assign write_ocw2 = strobe_q[STB_OCW2];
    assign write_ocw3 = strobe_q[STB_OCW3];

endmodule

// File: tb/tb_command_word_sequencer.sv
// tb_command_word_sequencer: directed checks of the init sequence, OCW decode, resets,
// held/aborted writes and back-to-back writes; seq_error checked when CMD_SEQ_ERROR_EN is set.
module tb_command_word_sequencer;

    localparam logic [6:0] S_ICW1 = 7'h01, S_ICW2 = 7'h02, S_ICW3 = 7'h04, S_ICW4 = 7'h08;
    localparam logic [6:0] S_OCW1 = 7'h10, S_OCW2 = 7'h20, S_OCW3 = 7'h40;

    logic       clock = 1'b0;
    logic       reset_n, chip_select_n, write_enable_n, address;
    logic [7:0] data_bus_in;
    logic [7:0] internal_data_bus, cascade_config;
    logic [4:0] vector_base;
    logic       write_icw1, write_icw2, write_icw3, write_icw4;
    logic       write_ocw1, write_ocw2, write_ocw3, init_in_progress;
    logic       config_ltim, config_adi, config_sngl, config_ic4;
    logic       config_upm, config_aeoi, config_ms, config_buf, config_sfnm;
`ifdef CMD_SEQ_ERROR_EN
    logic       seq_error_clear = 1'b0;
    logic       seq_error;
`endif

    command_word_sequencer #(.SYNC_STAGES(2), .RESET_VECTOR_BASE(5'h00)) dut (
        .clock(clock), .reset_n(reset_n),
`ifdef CMD_SEQ_ERROR_EN
        .seq_error_clear(seq_error_clear), .seq_error(seq_error),
`endif
        .chip_select_n(chip_select_n), .write_enable_n(write_enable_n),
        .address(address), .data_bus_in(data_bus_in), .internal_data_bus(internal_data_bus),
        .write_icw1(write_icw1), .write_icw2(write_icw2), .write_icw3(write_icw3),
        .write_icw4(write_icw4), .write_ocw1(write_ocw1), .write_ocw2(write_ocw2),
        .write_ocw3(write_ocw3), .init_in_progress(init_in_progress),
        .config_ltim(config_ltim), .config_adi(config_adi), .config_sngl(config_sngl),
        .config_ic4(config_ic4), .vector_base(vector_base), .cascade_config(cascade_config),
        .config_upm(config_upm), .config_aeoi(config_aeoi), .config_ms(config_ms),
        .config_buf(config_buf), .config_sfnm(config_sfnm)
    );

    always #5 clock = ~clock;

    logic [6:0] strobes;
    assign strobes = {write_ocw3, write_ocw2, write_ocw1, write_icw4, write_icw3, write_icw2, write_icw1};

    int         passed = 0, total = 0;
    logic [6:0] seen;
    logic [7:0] seen_data;
    int         pulses, first_cyc;
    logic [14:0] log_q[$];

    always @(negedge clock) if (|strobes) log_q.push_back({strobes, internal_data_bus});

    task automatic watch(input int n);
        seen = '0; seen_data = '0; pulses = 0; first_cyc = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (|strobes) begin
                pulses++;
                seen = seen | strobes;
                seen_data = internal_data_bus;
                if (first_cyc == 0) first_cyc = i;
            end
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = a; data_bus_in = d;
        repeat (2) @(negedge clock);
        write_enable_n = 1'b1; chip_select_n = 1'b1;
        watch(8);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; chip_select_n = 1'b1; write_enable_n = 1'b1; address = 1'b0; data_bus_in = 8'h00;
        repeat (3) @(negedge clock);
        total++; if (strobes !== 7'h00) $display("FAIL reset_strobes got %h want 00", strobes); else passed++;
        total++; if (init_in_progress !== 1'b0) $display("FAIL reset_init got %b want 0", init_in_progress); else passed++;
        total++; if (vector_base !== 5'h00) $display("FAIL reset_vector got %h want 00", vector_base); else passed++;
        total++; if (internal_data_bus !== 8'h00) $display("FAIL reset_data got %h want 00", internal_data_bus); else passed++;
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (strobes !== 7'h00) $display("FAIL reset_release_strobe got %h want 00", strobes); else passed++;
    endtask

    task automatic test_single;
        bus_write(1'b0, 8'h1A);
        total++; if (seen !== S_ICW1) $display("FAIL single_icw1 got %h want %h", seen, S_ICW1); else passed++;
        total++; if (pulses !== 1) $display("FAIL single_icw1_pulses got %0d want 1", pulses); else passed++;
        total++; if (first_cyc !== 3) $display("FAIL strobe_latency got %0d want 3", first_cyc); else passed++;
        total++; if ({config_ltim, config_adi, config_sngl, config_ic4} !== 4'b1010)
            $display("FAIL single_icw1_cfg got %b want 1010", {config_ltim, config_adi, config_sngl, config_ic4}); else passed++;
        total++; if (init_in_progress !== 1'b1) $display("FAIL single_init got %b want 1", init_in_progress); else passed++;
        bus_write(1'b1, 8'h48);
        total++; if (seen !== S_ICW2) $display("FAIL single_icw2 got %h want %h", seen, S_ICW2); else passed++;
        total++; if (vector_base !== 5'h09) $display("FAIL single_vector got %h want 09", vector_base); else passed++;
        total++; if (init_in_progress !== 1'b0) $display("FAIL single_ready got %b want 0", init_in_progress); else passed++;
    endtask

    task automatic test_cascade;
        bus_write(1'b0, 8'h11);
        total++; if ({config_ltim, config_sngl, config_ic4} !== 3'b001)
            $display("FAIL cascade_icw1_cfg got %b want 001", {config_ltim, config_sngl, config_ic4}); else passed++;
        bus_write(1'b1, 8'h20);
        total++; if (seen !== S_ICW2) $display("FAIL cascade_icw2 got %h want %h", seen, S_ICW2); else passed++;
        total++; if (vector_base !== 5'h04) $display("FAIL cascade_vector got %h want 04", vector_base); else passed++;
        bus_write(1'b1, 8'h04);
        total++; if (seen !== S_ICW3) $display("FAIL cascade_icw3 got %h want %h", seen, S_ICW3); else passed++;
        total++; if (cascade_config !== 8'h04) $display("FAIL cascade_cfg got %h want 04", cascade_config); else passed++;
        total++; if (init_in_progress !== 1'b1) $display("FAIL cascade_wait4 got %b want 1", init_in_progress); else passed++;
        bus_write(1'b1, 8'h03);
        total++; if (seen !== S_ICW4) $display("FAIL cascade_icw4 got %h want %h", seen, S_ICW4); else passed++;
        total++; if ({config_sfnm, config_buf, config_ms, config_aeoi, config_upm} !== 5'b00011)
            $display("FAIL cascade_icw4_cfg got %b want 00011", {config_sfnm, config_buf, config_ms, config_aeoi, config_upm}); else passed++;
        total++; if (init_in_progress !== 1'b0) $display("FAIL cascade_ready got %b want 0", init_in_progress); else passed++;
    endtask

    task automatic test_ocw;
        bus_write(1'b1, 8'hFB);
        total++; if (seen !== S_OCW1) $display("FAIL ocw1 got %h want %h", seen, S_OCW1); else passed++;
        total++; if (seen_data !== 8'hFB) $display("FAIL ocw1_data got %h want FB", seen_data); else passed++;
        bus_write(1'b0, 8'h20);
        total++; if (seen !== S_OCW2) $display("FAIL ocw2 got %h want %h", seen, S_OCW2); else passed++;
        total++; if (seen_data !== 8'h20) $display("FAIL ocw2_data got %h want 20", seen_data); else passed++;
        bus_write(1'b0, 8'h0B);
        total++; if (seen !== S_OCW3) $display("FAIL ocw3 got %h want %h", seen, S_OCW3); else passed++;
        total++; if (seen_data !== 8'h0B) $display("FAIL ocw3_data got %h want 0B", seen_data); else passed++;
        total++; if (vector_base !== 5'h04) $display("FAIL ocw_vector_hold got %h want 04", vector_base); else passed++;
    endtask

    task automatic test_illegal;
        bus_write(1'b0, 8'h13);
        total++; if (seen !== S_ICW1) $display("FAIL illegal_icw1 got %h want %h", seen, S_ICW1); else passed++;
        total++; if ({config_aeoi, config_upm} !== 2'b00) $display("FAIL icw4_clear got %b want 00", {config_aeoi, config_upm}); else passed++;
        bus_write(1'b0, 8'h20);
        total++; if (pulses !== 0) $display("FAIL illegal_pulses got %0d want 0", pulses); else passed++;
        total++; if (internal_data_bus !== 8'h20) $display("FAIL illegal_data got %h want 20", internal_data_bus); else passed++;
        total++; if (init_in_progress !== 1'b1) $display("FAIL illegal_state got %b want 1", init_in_progress); else passed++;
`ifdef CMD_SEQ_ERROR_EN
        total++; if (seq_error !== 1'b1) $display("FAIL seq_error_set got %b want 1", seq_error); else passed++;
`endif
        bus_write(1'b0, 8'h13);
        total++; if (seen !== S_ICW1) $display("FAIL restart_icw1 got %h want %h", seen, S_ICW1); else passed++;
`ifdef CMD_SEQ_ERROR_EN
        total++; if (seq_error !== 1'b0) $display("FAIL seq_error_clear got %b want 0", seq_error); else passed++;
`endif
        bus_write(1'b1, 8'h48);
        total++; if (seen !== S_ICW2) $display("FAIL restart_icw2 got %h want %h", seen, S_ICW2); else passed++;
        total++; if (init_in_progress !== 1'b1) $display("FAIL restart_wait4 got %b want 1", init_in_progress); else passed++;
        bus_write(1'b1, 8'h01);
        total++; if (seen !== S_ICW4) $display("FAIL restart_icw4 got %h want %h", seen, S_ICW4); else passed++;
        total++; if (config_upm !== 1'b1) $display("FAIL restart_upm got %b want 1", config_upm); else passed++;
        total++; if (cascade_config !== 8'h04) $display("FAIL cascade_hold got %h want 04", cascade_config); else passed++;
    endtask

    task automatic test_reset_mid;
        bus_write(1'b0, 8'h11);
        bus_write(1'b1, 8'h20);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++; if (init_in_progress !== 1'b0) $display("FAIL midreset_state got %b want 0", init_in_progress); else passed++;
        total++; if (vector_base !== 5'h00) $display("FAIL midreset_vector got %h want 00", vector_base); else passed++;
        total++; if (cascade_config !== 8'h00) $display("FAIL midreset_cascade got %h want 00", cascade_config); else passed++;
        total++; if (strobes !== 7'h00) $display("FAIL midreset_strobes got %h want 00", strobes); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (strobes !== 7'h00) $display("FAIL midreset_release got %h want 00", strobes); else passed++;
        bus_write(1'b1, 8'h77);
        total++; if (seen !== S_OCW1) $display("FAIL midreset_ready got %h want %h", seen, S_OCW1); else passed++;
    endtask

    task automatic test_held_low;
        int early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (|strobes) early++;
            chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'(8'h40 + i);
        end
        @(negedge clock);
        if (|strobes) early++;
        write_enable_n = 1'b1; chip_select_n = 1'b1;
        watch(8);
        total++; if (early + pulses !== 1) $display("FAIL held_count got %0d want 1", early + pulses); else passed++;
        total++; if (seen !== S_OCW1) $display("FAIL held_strobe got %h want %h", seen, S_OCW1); else passed++;
        total++; if (seen_data !== 8'h53) $display("FAIL held_data got %h want 53", seen_data); else passed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'(8'hC0 + i);
        end
        @(negedge clock);
        chip_select_n = 1'b1;
        @(negedge clock);
        write_enable_n = 1'b1;
        watch(8);
        total++; if (pulses !== 0) $display("FAIL cs_abort_pulses got %0d want 0", pulses); else passed++;
        total++; if (internal_data_bus !== 8'h53) $display("FAIL cs_abort_data got %h want 53", internal_data_bus); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp_q[4];
        logic [0:0]  a_v[4];
        logic [7:0]  d_v[4];
        exp_q = '{{S_OCW1, 8'hAA}, {S_OCW2, 8'h20}, {S_OCW3, 8'h08}, {S_OCW1, 8'h55}};
        a_v = '{1'b1, 1'b0, 1'b0, 1'b1};
        d_v = '{8'hAA, 8'h20, 8'h08, 8'h55};
        log_q.delete();
        @(negedge clock);
        chip_select_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_enable_n = 1'b0; address = a_v[i][0]; data_bus_in = d_v[i];
            repeat (2) @(negedge clock);
            write_enable_n = 1'b1;
            repeat (2) @(negedge clock);
        end
        chip_select_n = 1'b1;
        repeat (6) @(negedge clock);
        total++; if (log_q.size() !== 4) $display("FAIL b2b_count got %0d want 4", log_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= log_q.size()) $display("FAIL b2b_%0d got none want %h", i, exp_q[i]);
            else if (log_q[i] !== exp_q[i]) $display("FAIL b2b_%0d got %h want %h", i, log_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_cascade;
        test_ocw;
        test_illegal;
        test_reset_mid;
        test_held_low;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
